// File: rtl/fp32_normalize_shifter.sv
// Normalise a raw 49-bit mantissa with a leading-one shift code, round to nearest-even and pack binary32.
// Latency: valid_out follows valid_in by exactly 2 clocks; sign/exp/mant lead shift_code by ALIGN_DELAY clocks.
// Backpressure: none; valid-only pipeline accepting one op per clock.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   valid_in, shift_code     encoder output: 0x80 = right 1, 0..47 = left n, 0x40 = zero, else illegal
//   sign_in, exp_in, mant_in operand fields (hidden one at mant bit 47)
//   valid_out, out_data      packed {sign, exp, frac}; held while valid_out = 0
//   overflow, underflow, code_err  per-op flags, updated only with valid_out
module fp32_normalize_shifter #(
    parameter bit          ROUND_EN    = 1'b1,
    parameter int unsigned ALIGN_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [7:0]  shift_code,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [48:0] mant_in,
    output logic        valid_out,
    output logic [31:0] out_data,
    output logic        overflow,
    output logic        underflow,
    output logic        code_err
);

    // Operand fields aligned to the shift_code cycle
    logic        sign_a;
    logic [7:0]  exp_a;
    logic [48:0] mant_a;

    generate
        if (ALIGN_DELAY == 1) begin : g_align
            // Data-only register: qualification comes from valid_in, so no reset needed
            always_ff @(posedge clk) begin
                sign_a <= sign_in;
                exp_a  <= exp_in;
                mant_a <= mant_in;
            end
        end else begin : g_no_align
            assign sign_a = sign_in;
            assign exp_a  = exp_in;
            assign mant_a = mant_in;
        end
    endgenerate

    // ---------------- Stage 1: decode + coarse (byte) shift ----------------
    logic               code_right, code_left, code_zero, code_bad;
    logic [47:0]        m1;
    logic signed [9:0]  e1;
    logic [2:0]         fine1;

    always_comb begin
        code_right = (shift_code == 8'h80);
        code_left  = (shift_code[7:6] == 2'b00) && (shift_code[5:0] <= 6'd47);
        code_zero  = (shift_code == 8'h40);
        code_bad   = !(code_right || code_left || code_zero);
        m1    = '0;
        e1    = '0;
        fine1 = '0;
        if (code_right) begin
            // Carry-out into bit 48: move it down to the hidden position
            m1 = mant_a[48:1];
            e1 = $signed({2'b00, exp_a}) + 10'sd1;
        end else if (code_left) begin
            // Bit 48 is necessarily clear for a left-shift code, so 48 bits suffice
            m1    = mant_a[47:0] << {shift_code[5:3], 3'b000};
            e1    = $signed({2'b00, exp_a}) - $signed({4'b0000, shift_code[5:0]});
            fine1 = shift_code[2:0];
        end
    end

    logic               s1_vld, s1_sign, s1_zero, s1_err;
    logic [47:0]        s1_m;
    logic signed [9:0]  s1_e;
    logic [2:0]         s1_fine;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= valid_in;
        end
        s1_sign <= sign_a;
        s1_zero <= code_zero || code_bad;
        s1_err  <= code_bad;
        s1_m    <= m1;
        s1_e    <= e1;
        s1_fine <= fine1;
    end

    // ---------------- Stage 2: fine shift, round, classify, pack ----------------
    logic [47:0]        m2;
    logic               hidden_unused;
    logic [22:0]        frac;
    logic               guard, sticky, round_up;
    logic [23:0]        frac_sum;
    logic signed [9:0]  e2;
    logic [31:0]        pack;
    logic               ovf, unf;

    always_comb begin
        m2            = s1_m << s1_fine;
        // The hidden one is implied in the packed format and never stored
        hidden_unused = m2[47];
        frac          = m2[46:24];
        guard         = m2[23];
        sticky        = |m2[22:0];
        round_up      = ROUND_EN && guard && (sticky || frac[0]);
        frac_sum      = {1'b0, frac} + {23'd0, round_up};
        // On carry-out the low 23 bits are already zero; only the exponent bumps
        e2            = s1_e + $signed({9'd0, frac_sum[23]});
        ovf           = 1'b0;
        unf           = 1'b0;
        if (s1_zero) begin
            pack = {s1_sign, 31'd0};
        end else if (e2 >= 10'sd255) begin
            pack = {s1_sign, 8'hFF, 23'd0};
            ovf  = 1'b1;
        end else if (e2 <= 10'sd0) begin
            pack = {s1_sign, 31'd0};
            unf  = 1'b1;
        end else begin
            pack = {s1_sign, e2[7:0], frac_sum[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            code_err  <= 1'b0;
        end else begin
            valid_out <= s1_vld;
            if (s1_vld) begin
                out_data  <= pack;
                overflow  <= ovf;
                underflow <= unf;
                code_err  <= s1_err;
            end
        end
    end

endmodule
